// File: rtl/bst_search_insert_engine.sv
// rtl/bst_search_insert_engine.sv - command-driven BST insert/search engine over a node RAM
module bst_search_insert_engine #(
   parameter int          TOKEN_WIDTH    = 8,
   parameter int          PAYLOAD_WIDTH  = 32,
   parameter int          RAM_ADDR_WIDTH = 16,
   parameter int          RAM_DATA_WIDTH = PAYLOAD_WIDTH + 3*RAM_ADDR_WIDTH + TOKEN_WIDTH + 8,
   parameter int          MAX_DEPTH      = 16,
   parameter logic [7:0]  CMD_INSERT     = 8'h01,
   parameter logic [7:0]  CMD_SEARCH     = 8'h02
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      itf_valid,
   output logic                      itf_ready,
   input  logic [7:0]                itf_cmd,
   input  logic [TOKEN_WIDTH-1:0]    itf_token,
   input  logic [PAYLOAD_WIDTH-1:0]  itf_data,
   output logic                      cpl_valid,
   input  logic                      cpl_ready,
   output logic [2:0]                cpl_status,
   output logic [PAYLOAD_WIDTH-1:0]  cpl_data,
   output logic                      tree_mgt_req_valid,
   input  logic                      tree_mgt_req_ready,
   input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
   input  logic                      tree_mgt_full,
   output logic                      tree_mgt_free_valid,
   input  logic                      tree_mgt_free_ready,
   output logic [RAM_ADDR_WIDTH-1:0] tree_mgt_free_addr,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic                      mem_rd,
   output logic                      mem_wr,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
   output logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
   input  logic                      mem_rd_valid,
   output logic                      mem_rd_ready,
   input  logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
   output logic                      tree_empty
);
   localparam int TW     = TOKEN_WIDTH;
   localparam int PW     = PAYLOAD_WIDTH;
   localparam int AW     = RAM_ADDR_WIDTH;
   localparam int DW     = RAM_DATA_WIDTH;
   localparam int DEPW   = $clog2(MAX_DEPTH + 1);
   localparam int TOK_LO = 8;
   localparam int RGT_LO = 8 + TW + AW;
   localparam int LFT_LO = RGT_LO + AW;
   localparam int PAY_LO = LFT_LO + AW;

   typedef enum logic [3:0] {
      S_IDLE, S_DISPATCH, S_RD_REQ, S_RD_WAIT, S_COMPARE,
      S_ALLOC, S_WR_NODE, S_WR_PARENT, S_CPL
   } state_t;

   state_t          state, state_n;
   logic            alive;
   logic [7:0]      cmd_r, cmd_n;
   logic [TW-1:0]   token_r, token_n;
   logic [PW-1:0]   data_r, data_n;
   logic [DW-1:0]   node_r, node_n;
   logic [AW-1:0]   cur_addr, cur_n;
   logic [AW-1:0]   par_addr, par_n;
   logic [AW-1:0]   new_addr, new_n;
   logic            side_left, side_n;
   logic            upd, upd_n;
   logic            root_valid, root_valid_n;
   logic [AW-1:0]   root_addr, root_n;
   logic [DEPW-1:0] depth, depth_n;
   logic [2:0]      status, status_n;
   logic [DW-1:0]   parent_upd;
   logic [DW-1:0]   new_node;
   logic            go_left, child_present;
   logic [AW-1:0]   child_addr;

   wire unused_free_ready = &{1'b0, tree_mgt_free_ready};

   assign tree_mgt_free_valid = 1'b0;
   assign tree_mgt_free_addr  = '0;
   assign tree_empty          = ~root_valid;

   assign go_left       = token_r < node_r[TOK_LO +: TW];
   assign child_present = go_left ? node_r[1] : node_r[0];
   assign child_addr    = go_left ? node_r[LFT_LO +: AW] : node_r[RGT_LO +: AW];
   assign new_node      = {data_r, {AW{1'b0}}, {AW{1'b0}}, par_addr, token_r, 5'b0, ~root_valid, 2'b00};

   // Parent image with the recorded side's child link and has_child bit filled in
   always_comb begin
      parent_upd = node_r;
      if (side_left) begin
         parent_upd[LFT_LO +: AW] = new_addr;
         parent_upd[1]            = 1'b1;
      end else begin
         parent_upd[RGT_LO +: AW] = new_addr;
         parent_upd[0]            = 1'b1;
      end
   end

   // State and datapath registers; reset forgets the tree and drops any pending completion
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= S_IDLE;
         alive      <= 1'b0;
         cmd_r      <= '0;
         token_r    <= '0;
         data_r     <= '0;
         node_r     <= '0;
         cur_addr   <= '0;
         par_addr   <= '0;
         new_addr   <= '0;
         side_left  <= 1'b0;
         upd        <= 1'b0;
         root_valid <= 1'b0;
         root_addr  <= '0;
         depth      <= '0;
         status     <= '0;
      end else begin
         state      <= state_n;
         alive      <= 1'b1;
         cmd_r      <= cmd_n;
         token_r    <= token_n;
         data_r     <= data_n;
         node_r     <= node_n;
         cur_addr   <= cur_n;
         par_addr   <= par_n;
         new_addr   <= new_n;
         side_left  <= side_n;
         upd        <= upd_n;
         root_valid <= root_valid_n;
         root_addr  <= root_n;
         depth      <= depth_n;
         status     <= status_n;
      end
   end

   // Next-state, next-datapath and bus outputs; outputs are zero unless the state drives them
   always_comb begin
      state_n            = state;
      cmd_n              = cmd_r;
      token_n            = token_r;
      data_n             = data_r;
      node_n             = node_r;
      cur_n              = cur_addr;
      par_n              = par_addr;
      new_n              = new_addr;
      side_n             = side_left;
      upd_n              = upd;
      root_valid_n       = root_valid;
      root_n             = root_addr;
      depth_n            = depth;
      status_n           = status;
      itf_ready          = 1'b0;
      cpl_valid          = 1'b0;
      cpl_status         = '0;
      cpl_data           = '0;
      tree_mgt_req_valid = 1'b0;
      mem_valid          = 1'b0;
      mem_rd             = 1'b0;
      mem_wr             = 1'b0;
      mem_addr           = '0;
      mem_wr_data        = '0;
      mem_rd_ready       = 1'b0;
      case (state)
         S_IDLE: begin
            itf_ready = alive;
            if (alive && itf_valid) begin
               cmd_n   = itf_cmd;
               token_n = itf_token;
               data_n  = itf_data;
               upd_n   = 1'b0;
               state_n = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (cmd_r != CMD_INSERT && cmd_r != CMD_SEARCH) begin
               status_n = 3'd6;
               state_n  = S_CPL;
            end else if (!root_valid) begin
               if (cmd_r == CMD_SEARCH) begin
                  status_n = 3'd3;
                  state_n  = S_CPL;
               end else begin
                  par_n   = '0;
                  state_n = S_ALLOC;
               end
            end else begin
               cur_n   = root_addr;
               depth_n = '0;
               state_n = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            mem_valid = 1'b1;
            mem_rd    = 1'b1;
            mem_addr  = cur_addr;
            if (mem_ready) begin
               depth_n = depth + DEPW'(1);
               state_n = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            mem_rd_ready = 1'b1;
            if (mem_rd_valid) begin
               node_n  = mem_rd_data;
               state_n = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (token_r == node_r[TOK_LO +: TW]) begin
               if (cmd_r == CMD_SEARCH) begin
                  status_n = 3'd2;
                  state_n  = S_CPL;
               end else begin
                  upd_n   = 1'b1;
                  state_n = S_WR_NODE;
               end
            end else if (child_present) begin
               if (depth == DEPW'(MAX_DEPTH)) begin
                  status_n = 3'd5;
                  state_n  = S_CPL;
               end else begin
                  cur_n   = child_addr;
                  state_n = S_RD_REQ;
               end
            end else if (cmd_r == CMD_SEARCH) begin
               status_n = 3'd3;
               state_n  = S_CPL;
            end else begin
               side_n  = go_left;
               par_n   = cur_addr;
               state_n = S_ALLOC;
            end
         end
         S_ALLOC: begin
            if (tree_mgt_full) begin
               status_n = 3'd4;
               state_n  = S_CPL;
            end else begin
               tree_mgt_req_valid = 1'b1;
               if (tree_mgt_req_ready) begin
                  new_n   = tree_mgt_req_addr;
                  state_n = S_WR_NODE;
               end
            end
         end
         S_WR_NODE: begin
            mem_valid = 1'b1;
            mem_wr    = 1'b1;
            if (upd) begin
               mem_addr    = cur_addr;
               mem_wr_data = {data_r, node_r[PAY_LO-1:0]};
            end else begin
               mem_addr    = new_addr;
               mem_wr_data = new_node;
            end
            if (mem_ready) begin
               if (upd) begin
                  status_n = 3'd1;
                  state_n  = S_CPL;
               end else if (!root_valid) begin
                  root_n       = new_addr;
                  root_valid_n = 1'b1;
                  status_n     = 3'd0;
                  state_n      = S_CPL;
               end else begin
                  state_n = S_WR_PARENT;
               end
            end
         end
         S_WR_PARENT: begin
            mem_valid   = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = par_addr;
            mem_wr_data = parent_upd;
            if (mem_ready) begin
               status_n = 3'd0;
               state_n  = S_CPL;
            end
         end
         S_CPL: begin
            cpl_valid  = 1'b1;
            cpl_status = status;
            cpl_data   = (status == 3'd2) ? node_r[PAY_LO +: PW] : '0;
            if (cpl_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_bst_search_insert_engine.sv
// tb/tb_bst_search_insert_engine.sv - scoreboard bench for bst_search_insert_engine
module tb_bst_search_insert_engine;
   localparam int TW = 8;
   localparam int PW = 32;
   localparam int AW = 16;
   localparam int DW = 96;

   logic          aclk, aresetn;
   logic          itf_valid, itf_ready;
   logic [7:0]    itf_cmd;
   logic [TW-1:0] itf_token;
   logic [PW-1:0] itf_data;
   logic          cpl_valid, cpl_ready;
   logic [2:0]    cpl_status;
   logic [PW-1:0] cpl_data;
   logic          tree_mgt_req_valid, tree_mgt_req_ready;
   logic [AW-1:0] tree_mgt_req_addr;
   logic          tree_mgt_full;
   logic          tree_mgt_free_valid, tree_mgt_free_ready;
   logic [AW-1:0] tree_mgt_free_addr;
   logic          mem_valid, mem_ready, mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd_valid, mem_rd_ready;
   logic [DW-1:0] mem_rd_data;
   logic          tree_empty;

   bst_search_insert_engine #(.MAX_DEPTH(2)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .itf_valid(itf_valid), .itf_ready(itf_ready), .itf_cmd(itf_cmd),
      .itf_token(itf_token), .itf_data(itf_data),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_status(cpl_status), .cpl_data(cpl_data),
      .tree_mgt_req_valid(tree_mgt_req_valid), .tree_mgt_req_ready(tree_mgt_req_ready),
      .tree_mgt_req_addr(tree_mgt_req_addr), .tree_mgt_full(tree_mgt_full),
      .tree_mgt_free_valid(tree_mgt_free_valid), .tree_mgt_free_ready(tree_mgt_free_ready),
      .tree_mgt_free_addr(tree_mgt_free_addr),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
      .tree_empty(tree_empty)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { logic [2:0] st; logic [PW-1:0] d; } cpl_t;
   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   cpl_t          exp_cpl[$];
   wr_t           ew;
   cpl_t          ec;
   logic [AW-1:0] er;
   int checks = 0;
   int errors = 0;
   int alloc_cnt = 0;
   logic rd_hold;
   logic [DW-1:0] ram [0:15];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [31:0] p, input logic [15:0] l, input logic [15:0] r,
                                        input logic [15:0] par, input logic [7:0] t, input logic [7:0] info);
      return {p, l, r, par, t, info};
   endfunction

   // Memory and allocator responder: one-cycle read latency unless held off
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mem_rd_valid <= 1'b0;
         mem_rd_data  <= '0;
      end else begin
         if (mem_rd_valid && mem_rd_ready) mem_rd_valid <= 1'b0;
         if (mem_valid && mem_ready && mem_rd && !rd_hold) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= ram[mem_addr[3:0]];
         end
         if (mem_valid && mem_ready && mem_wr) ram[mem_addr[3:0]] <= mem_wr_data;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a transfer
   always @(negedge aclk) begin
      if (mem_valid) check("rd_wr_exclusive", 128'(mem_rd & mem_wr), 128'(0));
      if (mem_valid && mem_ready && mem_wr) begin
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0h, expected no write", mem_addr);
         end else begin
            ew = exp_wr.pop_front();
            check("wr_addr", 128'(mem_addr), 128'(ew.addr));
            check("wr_data", 128'(mem_wr_data), 128'(ew.data));
         end
      end
      if (mem_valid && mem_ready && mem_rd) begin
         if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: got addr %0h, expected no read", mem_addr);
         end else begin
            er = exp_rd.pop_front();
            check("rd_addr", 128'(mem_addr), 128'(er));
         end
      end
      if (tree_mgt_req_valid && tree_mgt_req_ready) alloc_cnt++;
      if (cpl_valid && cpl_ready) begin
         if (exp_cpl.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cpl: got status %0d, expected no completion", cpl_status);
         end else begin
            ec = exp_cpl.pop_front();
            check("cpl_status", 128'(cpl_status), 128'(ec.st));
            check("cpl_data", 128'(cpl_data), 128'(ec.d));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_itf_ready"}, 128'(itf_ready), 128'(0));
      check({tag, "_cpl"}, 128'({cpl_valid, cpl_status, cpl_data}), 128'(0));
      check({tag, "_tree_mgt"}, 128'({tree_mgt_req_valid, tree_mgt_free_valid, tree_mgt_free_addr}), 128'(0));
      check({tag, "_mem_ctl"}, 128'({mem_valid, mem_rd, mem_wr, mem_rd_ready, mem_addr}), 128'(0));
      check({tag, "_mem_wr_data"}, 128'(mem_wr_data), 128'(0));
      check({tag, "_tree_empty"}, 128'(tree_empty), 128'(1));
   endtask

   task automatic do_reset(input string tag);
      aresetn = 1'b0;
      itf_valid = 1'b0;
      cpl_ready = 1'b1;
      rd_hold = 1'b0;
      tree_mgt_full = 1'b0;
      exp_wr.delete(); exp_rd.delete(); exp_cpl.delete();
      #1;
      check_reset_outputs(tag);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      alloc_cnt = 0;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] t, input logic [31:0] d);
      @(negedge aclk);
      itf_cmd = c; itf_token = t; itf_data = d; itf_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (itf_ready) break;
         @(negedge aclk);
      end
      check("cmd_accept", 128'(itf_ready), 128'(1));
      @(posedge aclk);
      #1 itf_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (exp_cpl.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0) break;
         @(negedge aclk);
      end
      check({tag, "_drain"}, 128'({exp_cpl.size(), exp_wr.size(), exp_rd.size()}), 128'(0));
      exp_wr.delete(); exp_rd.delete(); exp_cpl.delete();
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [DW-1:0] d);
      wr_t w; w.addr = a; w.data = d; exp_wr.push_back(w);
   endtask
   task automatic push_cpl(input logic [2:0] s, input logic [31:0] d);
      cpl_t c; c.st = s; c.d = d; exp_cpl.push_back(c);
   endtask

   initial begin
      itf_cmd = '0; itf_token = '0; itf_data = '0; itf_valid = 1'b0;
      tree_mgt_req_ready = 1'b1; tree_mgt_req_addr = '0; tree_mgt_free_ready = 1'b1;
      mem_ready = 1'b1; cpl_ready = 1'b1; rd_hold = 1'b0; tree_mgt_full = 1'b0;
      aresetn = 1'b1;
      #2;

      // Root insert into an empty tree at slot 3
      do_reset("rst_a");
      check("ready_after_reset", 128'(itf_ready), 128'(1));
      tree_mgt_req_addr = 16'h0003;
      push_wr(16'h0003, mk(32'hCAFE0040, 0, 0, 0, 8'h40, 8'h04));
      push_cpl(3'd0, 0);
      send(8'h01, 8'h40, 32'hCAFE0040);
      drain("root_insert");
      check("root_alloc_cnt", 128'(alloc_cnt), 128'(1));
      check("tree_empty_fall", 128'(tree_empty), 128'(0));

      // Three-node tree 0x40 / 0x20 / 0x60 at slots 1 / 2 / 3
      do_reset("rst_b");
      tree_mgt_req_addr = 16'h0001;
      push_wr(1, mk(32'h11110040, 0, 0, 0, 8'h40, 8'h04)); push_cpl(0, 0);
      send(8'h01, 8'h40, 32'h11110040); drain("ins_40");
      tree_mgt_req_addr = 16'h0002;
      exp_rd.push_back(1);
      push_wr(2, mk(32'h22220020, 0, 0, 1, 8'h20, 8'h00));
      push_wr(1, mk(32'h11110040, 2, 0, 0, 8'h40, 8'h06)); push_cpl(0, 0);
      send(8'h01, 8'h20, 32'h22220020); drain("ins_20");
      tree_mgt_req_addr = 16'h0003;
      exp_rd.push_back(1);
      push_wr(3, mk(32'h33330060, 0, 0, 1, 8'h60, 8'h00));
      push_wr(1, mk(32'h11110040, 2, 3, 0, 8'h40, 8'h07)); push_cpl(0, 0);
      send(8'h01, 8'h60, 32'h33330060); drain("ins_60");
      check("tree_alloc_cnt", 128'(alloc_cnt), 128'(3));
      exp_rd.push_back(1); exp_rd.push_back(3); push_cpl(2, 32'h33330060);
      send(8'h02, 8'h60, 0); drain("search_60");
      exp_rd.push_back(1); exp_rd.push_back(2);
      push_wr(2, mk(32'h0000DEAD, 0, 0, 1, 8'h20, 8'h00)); push_cpl(1, 0);
      send(8'h01, 8'h20, 32'h0000DEAD); drain("update_20");
      check("update_no_alloc", 128'(alloc_cnt), 128'(3));
      exp_rd.push_back(1); exp_rd.push_back(3); push_cpl(3, 0);
      send(8'h02, 8'h55, 0); drain("search_55");
      exp_rd.push_back(1); exp_rd.push_back(2); push_cpl(2, 32'h0000DEAD);
      send(8'h02, 8'h20, 0); drain("search_20");
      tree_mgt_full = 1'b1;
      exp_rd.push_back(1); exp_rd.push_back(3); push_cpl(4, 0);
      send(8'h01, 8'h70, 32'h77777777); drain("full");
      check("full_no_alloc", 128'(alloc_cnt), 128'(3));
      tree_mgt_full = 1'b0;
      push_cpl(6, 0);
      send(8'h7F, 8'h40, 0); drain("badcmd");

      // Ascending chain with MAX_DEPTH=2 and completion back-pressure
      do_reset("rst_c");
      push_cpl(3, 0);
      send(8'h02, 8'h01, 0); drain("search_empty");
      tree_mgt_req_addr = 16'h0001;
      push_wr(1, mk(32'hA1, 0, 0, 0, 8'h01, 8'h04)); push_cpl(0, 0);
      send(8'h01, 8'h01, 32'hA1); drain("asc_1");
      tree_mgt_req_addr = 16'h0002;
      exp_rd.push_back(1);
      push_wr(2, mk(32'hA2, 0, 0, 1, 8'h02, 8'h00));
      push_wr(1, mk(32'hA1, 0, 2, 0, 8'h01, 8'h05)); push_cpl(0, 0);
      send(8'h01, 8'h02, 32'hA2); drain("asc_2");
      tree_mgt_req_addr = 16'h0003;
      exp_rd.push_back(1); exp_rd.push_back(2);
      push_wr(3, mk(32'hA3, 0, 0, 2, 8'h03, 8'h00));
      push_wr(2, mk(32'hA2, 0, 3, 1, 8'h02, 8'h01)); push_cpl(0, 0);
      send(8'h01, 8'h03, 32'hA3); drain("asc_3");
      tree_mgt_req_addr = 16'h0004;
      cpl_ready = 1'b0;
      exp_rd.push_back(1); exp_rd.push_back(2); push_cpl(5, 0);
      send(8'h01, 8'h04, 32'hA4);
      for (int i = 0; i < 100; i++) begin
         if (cpl_valid) break;
         @(negedge aclk);
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_cpl_valid", 128'(cpl_valid), 128'(1));
         check("hold_cpl_status", 128'(cpl_status), 128'(5));
         check("hold_cpl_data", 128'(cpl_data), 128'(0));
         check("hold_itf_ready", 128'(itf_ready), 128'(0));
         @(negedge aclk);
      end
      cpl_ready = 1'b1;
      drain("depth");
      check("depth_alloc_cnt", 128'(alloc_cnt), 128'(3));

      // Reset asserted while a read completion is outstanding
      rd_hold = 1'b1;
      exp_rd.push_back(1);
      send(8'h02, 8'h03, 0);
      for (int i = 0; i < 100; i++) begin
         if (mem_rd_ready) break;
         @(negedge aclk);
      end
      check("reached_rd_wait", 128'(mem_rd_ready), 128'(1));
      #2;
      do_reset("rst_mid");
      push_cpl(3, 0);
      send(8'h02, 8'h03, 0); drain("post_reset_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bst_search_insert_engine.md
Name: bst_search_insert_engine

Overview:
- Command-driven binary-search-tree engine: INSERT and SEARCH of (token, payload) pairs over a node RAM behind the memory driver.
- Node slots come from the tree space manager.
- Successor to the insert-only engine, adding:
  - a search command;
  - in-place payload update on duplicate token;
  - full read-modify-write update of the parent node;
  - a depth guard;
  - a completion channel that reports status and read data.
- Sits between the user command AXI4-stream and the memory driver / tree manager.

Parameters:
TOKEN_WIDTH, 8, token (key) width
PAYLOAD_WIDTH, 32, payload width
RAM_ADDR_WIDTH, 16, node address width
RAM_DATA_WIDTH, PAYLOAD_WIDTH+3*RAM_ADDR_WIDTH+TOKEN_WIDTH+8, node width; any other value is illegal
MAX_DEPTH, 16, maximum number of node reads per command before abort
CMD_INSERT, 8'h01, insert opcode
CMD_SEARCH, 8'h02, search opcode

Ports:
aclk  in  1  clock
aresetn  in  1  reset
itf_valid/itf_ready  in/out  1  command handshake
itf_cmd  in  8  opcode
itf_token  in  TOKEN_WIDTH  key
itf_data  in  PAYLOAD_WIDTH  payload (INSERT only)
cpl_valid/cpl_ready  out/in  1  completion handshake
cpl_status  out  3  result code
cpl_data  out  PAYLOAD_WIDTH  payload found (SEARCH), else 0
tree_mgt_req_valid/ready  out/in  1  slot allocation handshake
tree_mgt_req_addr  in  RAM_ADDR_WIDTH  allocated slot
tree_mgt_full  in  1  no free slot
tree_mgt_free_valid  out  1  tied 0
tree_mgt_free_ready  in  1  unused
tree_mgt_free_addr  out  RAM_ADDR_WIDTH  tied 0
mem_valid/mem_ready  out/in  1  memory request handshake
mem_rd, mem_wr  out  1  request type
mem_addr  out  RAM_ADDR_WIDTH  node address
mem_wr_data  out  RAM_DATA_WIDTH  node to write
mem_rd_valid/mem_rd_ready  in/out  1  read completion handshake
mem_rd_data  in  RAM_DATA_WIDTH  node read
tree_empty  out  1  no root written yet

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: all outputs 0, except tree_empty=1. Internal state: fsm=IDLE, root_valid=0, root_addr=0, depth=0.
- Reset mid-operation: abort immediately and drop any pending completion. The tree is considered empty afterwards; RAM contents are ignored.
- Node layout, MSB to LSB: {payload, left_addr, right_addr, parent_addr, token, info[7:0]}.
  - info[2]=is_root, info[1]=has_left, info[0]=has_right.
  - info[7:3] written 0.
- Command accept:
  - itf_ready=1 only in IDLE.
  - On handshake, cmd, token and data are registered; the next state is DISPATCH.
- DISPATCH:
  - Unknown opcode -> CPL with status 6 (BADCMD).
  - SEARCH with root_valid=0 -> CPL with status 3 (NOT_FOUND).
  - INSERT with root_valid=0 -> ALLOC (root insert).
  - Otherwise: cur_addr=root_addr, depth=0 -> RD_REQ.
- RD_REQ: mem_valid=mem_rd=1, mem_addr=cur_addr. Held until mem_ready -> RD_WAIT; depth increments on acceptance.
- RD_WAIT: mem_rd_ready=1. On mem_rd_valid, the node is latched -> COMPARE.
- COMPARE (token vs node token, unsigned):
  - Equal, SEARCH: cpl_data=node payload, status 2 (FOUND) -> CPL.
  - Equal, INSERT: new node = read node with payload replaced; write to cur_addr (WR_NODE); status 1 (UPDATED). No allocation.
  - Less/greater, with that child present:
    - depth==MAX_DEPTH -> CPL with status 5 (DEPTH).
    - Otherwise cur_addr=child address -> RD_REQ.
  - Less/greater, child absent:
    - SEARCH -> CPL with status 3.
    - INSERT -> record side (left if less), parent_addr=cur_addr -> ALLOC.
- ALLOC:
  - If tree_mgt_full=1 at state entry or while waiting -> CPL with status 4 (FULL); no writes occur.
  - Otherwise tree_mgt_req_valid=1 until tree_mgt_req_ready. new_addr is sampled in the handshake cycle -> WR_NODE.
- WR_NODE:
  - Writes {data, 0, 0, parent_addr, token, is_root, 0, 0} at new_addr, held until mem_ready.
  - Root case: root_addr=new_addr, root_valid=1, status 0 -> CPL.
  - Child case -> WR_PARENT.
- WR_PARENT:
  - Writes the latched parent node with the side's child address set to new_addr and the has_child bit set; all other fields unchanged. Address is parent_addr.
  - Status 0 (INSERTED) -> CPL.
- CPL:
  - cpl_valid=1; status and data held stable until cpl_ready -> IDLE.
  - cpl_data=0 for every status except 2.
- Bus rules:
  - mem_valid never asserts outside RD_REQ/WR_NODE/WR_PARENT.
  - mem_rd and mem_wr are mutually exclusive.
  - Request fields are stable while mem_valid=1 and mem_ready=0.
- Status codes: 0 INSERTED, 1 UPDATED, 2 FOUND, 3 NOT_FOUND, 4 FULL, 5 DEPTH, 6 BADCMD.

Test Plan:
- INSERT tok 0x40 into empty tree, allocator returns 0x0003 -> one write at 0x0003 with info=0x04; tree_empty falls; cpl_status=0.
- INSERT 0x40, 0x20, 0x60 (addresses 1, 2, 3) -> parent 1 rewritten with left=2 and info bit1, then right=3 and bit0; SEARCH 0x60 -> status 2 with payload.
- INSERT 0x20 again with data 0xDEAD -> no allocation request; single write to address 2 with payload 0xDEAD; status 1.
- SEARCH 0x55 on that tree -> two reads (addresses 1, 3); status 3; cpl_data=0.
- INSERT with tree_mgt_full=1 -> no mem_wr; status 4. Opcode 0x7F -> status 6.
- MAX_DEPTH=2, insert ascending 1,2,3,4 -> fourth insert returns status 5. Hold cpl_ready low 5 cycles -> outputs stable and itf_ready=0. Assert aresetn low mid-RD_WAIT -> all outputs return to reset values.
